// File: rtl/uart_recv_word.sv
// UART 8N1 receiver that pairs two bytes (low first) into a 16-bit word.
// Optional inter-byte timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_recv_word #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int UART_BPS     = 115200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [15:0] uart_dout,
  output logic        uart_done,
  output logic        rx_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] HALF_LAST = 16'(BPS_CNT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
`ifdef UART_RX_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * BPS_CNT - 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  logic        rx_meta_r, rx_sync_r, rx_dly_r;
  logic        fall_s;
  state_t      state_r, state_s;
  logic [15:0] clk_cnt_r, clk_cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic        byte_idx_r, byte_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  low_byte_r, low_byte_s;
  logic [15:0] dout_r, dout_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] gap_cnt_r, gap_cnt_s;
`endif

  assign fall_s    = rx_dly_r & ~rx_sync_r;
  assign uart_dout = dout_r;
  assign uart_done = done_r;
  assign rx_err    = err_r;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_dly_r  <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_dly_r  <= rx_sync_r;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      clk_cnt_r  <= 16'd0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 1'b0;
      shift_r    <= 8'h00;
      low_byte_r <= 8'h00;
      dout_r     <= 16'h0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      gap_cnt_r  <= 32'd0;
`endif
    end else begin
      state_r    <= state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      shift_r    <= shift_s;
      low_byte_r <= low_byte_s;
      dout_r     <= dout_s;
      done_r     <= done_s;
      err_r      <= err_s;
`ifdef UART_RX_TIMEOUT_EN
      gap_cnt_r  <= gap_cnt_s;
`endif
    end
  end

  // Next-state and datapath updates; pulses default low every cycle.
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    shift_s    = shift_r;
    low_byte_s = low_byte_r;
    dout_s     = dout_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    gap_cnt_s  = gap_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          clk_cnt_s  = 16'd0;
          byte_idx_s = 1'b0;
          state_s    = START;
        end else begin
          state_s    = IDLE;
        end
      end
      START: begin
        if (clk_cnt_r == HALF_LAST) begin
          clk_cnt_s = 16'd0;
          if (!rx_sync_r) begin
            bit_idx_s = 3'd0;
            state_s   = DATA;
          end else if (byte_idx_r) begin
            // Glitch while waiting for the high byte keeps the low byte.
            state_s   = GAP;
`ifdef UART_RX_TIMEOUT_EN
            gap_cnt_s = 32'd0;
`endif
          end else begin
            state_s   = IDLE;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s = 16'd0;
          shift_s   = {rx_sync_r, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s = 16'd0;
          if (!rx_sync_r) begin
            err_s      = 1'b1;
            low_byte_s = 8'h00;
            byte_idx_s = 1'b0;
            state_s    = IDLE;
          end else if (!byte_idx_r) begin
            low_byte_s = shift_r;
            state_s    = GAP;
`ifdef UART_RX_TIMEOUT_EN
            gap_cnt_s  = 32'd0;
`endif
          end else begin
            dout_s     = {shift_r, low_byte_r};
            done_s     = 1'b1;
            byte_idx_s = 1'b0;
            state_s    = IDLE;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + 16'd1;
        end
      end
      GAP: begin
        if (fall_s) begin
          byte_idx_s = 1'b1;
          clk_cnt_s  = 16'd0;
          state_s    = START;
`ifdef UART_RX_TIMEOUT_EN
        end else if (gap_cnt_r == TIMEOUT_LAST) begin
          err_s      = 1'b1;
          low_byte_s = 8'h00;
          byte_idx_s = 1'b0;
          state_s    = IDLE;
        end else begin
          gap_cnt_s  = gap_cnt_r + 32'd1;
        end
`else
        end else begin
          state_s    = GAP;
        end
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_recv_word.sv
// Bench for uart_recv_word: vector table, hand sequences and random words
// checked against a word-level model of the receiver.
module tb_uart_recv_word;

  localparam int B    = 32;   // small instance: 3.2 MHz / 100 kBd
  localparam int H    = B / 2;
  localparam int DB   = 868;  // default-parameter instance
  localparam int DH   = DB / 2;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b;
  logic [15:0] dout_a, dout_b;
  logic done_a, done_b, err_a, err_b;

  always #5 clk = ~clk;

  uart_recv_word dut_def (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a),
    .uart_dout(dout_a), .uart_done(done_a), .rx_err(err_a)
  );

  uart_recv_word #(.CLK_FREQ(3_200_000), .UART_BPS(100_000), .TIMEOUT_BITS(TO_B)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_b),
    .uart_dout(dout_b), .uart_done(done_b), .rx_err(err_b)
  );

  int cyc = 0;
  int n_done_a = 0, n_err_a = 0, n_done_b = 0, n_err_b = 0, n_both = 0;
  int done_cyc_a = 0, done_cyc_b = 0, err_cyc_b = 0;
  int total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) begin n_done_a <= n_done_a + 1; done_cyc_a <= cyc; end
    if (err_a) n_err_a <= n_err_a + 1;
    if (done_b) begin n_done_b <= n_done_b + 1; done_cyc_b <= cyc; end
    if (err_b) begin n_err_b <= n_err_b + 1; err_cyc_b <= cyc; end
    if ((done_a && err_a) || (done_b && err_b)) n_both <= n_both + 1;
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_near(input string name, input longint act, input longint exp);
    total++;
    if (act < exp - 3 || act > exp + 3) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d +/-3", name, act, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_a = v;
    else     rx_b = v;
  endtask

  task automatic idle_bits(input bit sel, input int n);
    set_rx(sel, 1'b1);
    repeat (n * (sel ? DB : B)) @(negedge clk);
  endtask

  // One 8N1 frame; start_cyc is the cycle the start bit's falling edge is driven.
  task automatic send_byte(input bit sel, input logic [7:0] v, input logic stop,
                           output int start_cyc);
    int bp;
    bp = sel ? DB : B;
    @(negedge clk);
    start_cyc = cyc;
    set_rx(sel, 1'b0);
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, v[i]);
      repeat (bp) @(negedge clk);
    end
    set_rx(sel, stop);
    repeat (bp) @(negedge clk);
    set_rx(sel, 1'b1);
  endtask

  task automatic send_word(input bit sel, input logic [7:0] lo, input logic [7:0] hi,
                           input logic hi_stop, input int gap, input int post,
                           output int hi_start);
    int s;
    send_byte(sel, lo, 1'b1, s);
    idle_bits(sel, gap);
    send_byte(sel, hi, hi_stop, hi_start);
    idle_bits(sel, post);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        hi_stop;
    int          gap;
    int          exp_done;
    int          exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] model_dout;
  int d0, e0, s0, s1;
  logic [7:0] rlo, rhi;
  logic rstop;

  initial begin
    vecs[0] = '{8'h34, 8'h12, 1'b1, 0, 1, 0, 16'h1234};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 0, 1, 0, 16'hFFFF};
    vecs[2] = '{8'h11, 8'h11, 1'b1, 2, 1, 0, 16'h1111};
    vecs[3] = '{8'hEF, 8'hBE, 1'b0, 0, 0, 1, 16'h1111};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 3, 1, 0, 16'h00FF};
    vecs[5] = '{8'h00, 8'h80, 1'b1, 1, 1, 0, 16'h8000};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (4) @(negedge clk);
    cmp("rst_dout", dout_b, 16'h0000);
    cmp("rst_done", done_b, 0);
    cmp("rst_err", err_b, 0);
    cmp("rst_dout_def", dout_a, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Default parameters: 0xA55A at 868 clocks per bit.
    send_word(1'b1, 8'h5A, 8'hA5, 1'b1, 0, 1, s1);
    cmp("def_done_cnt", n_done_a, 1);
    cmp("def_err_cnt", n_err_a, 0);
    cmp("def_dout", dout_a, 16'hA55A);
    cmp_near("def_latency", done_cyc_a - s1, 2 + DH + 9 * DB);

    // Vector table, one idle bit between words.
    for (int i = 0; i < 6; i++) begin
      d0 = n_done_b; e0 = n_err_b;
      send_word(1'b0, vecs[i].lo, vecs[i].hi, vecs[i].hi_stop, vecs[i].gap, 1, s1);
      cmp($sformatf("vec%0d_done", i), n_done_b - d0, vecs[i].exp_done);
      cmp($sformatf("vec%0d_err", i), n_err_b - e0, vecs[i].exp_err);
      cmp($sformatf("vec%0d_dout", i), dout_b, vecs[i].exp_dout);
      if (vecs[i].exp_done != 0)
        cmp_near($sformatf("vec%0d_lat", i), done_cyc_b - s1, 2 + H + 9 * B);
    end
    model_dout = 16'h8000;

    // Short low glitch in IDLE, then a real word.
    d0 = n_done_b; e0 = n_err_b;
    @(negedge clk); rx_b = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(1'b0, 3);
    cmp("glitch_done", n_done_b - d0, 0);
    cmp("glitch_err", n_err_b - e0, 0);
    send_word(1'b0, 8'h01, 8'h00, 1'b1, 0, 1, s1);
    cmp("glitch_word_done", n_done_b - d0, 1);
    cmp("glitch_word_dout", dout_b, 16'h0001);

    // Glitch between the two bytes must keep the stored low byte.
    d0 = n_done_b; e0 = n_err_b;
    send_byte(1'b0, 8'h22, 1'b1, s0);
    idle_bits(1'b0, 1);
    @(negedge clk); rx_b = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(1'b0, 2);
    send_byte(1'b0, 8'h11, 1'b1, s1);
    idle_bits(1'b0, 1);
    cmp("gapglitch_done", n_done_b - d0, 1);
    cmp("gapglitch_err", n_err_b - e0, 0);
    cmp("gapglitch_dout", dout_b, 16'h1122);
    model_dout = 16'h1122;

    // Random words against the word-level model.
    for (int k = 0; k < 24; k++) begin
      rlo = 8'($urandom); rhi = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      d0 = n_done_b; e0 = n_err_b;
      send_word(1'b0, rlo, rhi, rstop, $urandom_range(0, 4), $urandom_range(1, 3), s1);
      if (rstop) model_dout = {rhi, rlo};
      cmp($sformatf("rnd%0d_done", k), n_done_b - d0, rstop ? 1 : 0);
      cmp($sformatf("rnd%0d_err", k), n_err_b - e0, rstop ? 0 : 1);
      cmp($sformatf("rnd%0d_dout", k), dout_b, model_dout);
    end

    // Lone low byte, long idle, then two more bytes.
    d0 = n_done_b; e0 = n_err_b;
    send_byte(1'b0, 8'h34, 1'b1, s0);
    idle_bits(1'b0, 20);
    send_byte(1'b0, 8'h78, 1'b1, s1);
    idle_bits(1'b0, 0);
    send_byte(1'b0, 8'h56, 1'b1, s1);
    idle_bits(1'b0, 2);
`ifdef UART_RX_TIMEOUT_EN
    cmp("to_err", n_err_b - e0, 1);
    cmp("to_done", n_done_b - d0, 1);
    cmp("to_dout", dout_b, 16'h5678);
    cmp_near("to_err_time", err_cyc_b - s0, 2 + H + 9 * B + TO_B * B);
`else
    cmp("to_err", n_err_b - e0, 0);
    cmp("to_done", n_done_b - d0, 1);
    cmp("to_dout", dout_b, 16'h7834);
`endif

    // Reset during data bit 4 of a low byte.
    d0 = n_done_b; e0 = n_err_b;
    @(negedge clk); rx_b = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_b = i[0];
      repeat (B) @(negedge clk);
    end
    rx_b = 1'b1;
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp("midrst_dout", dout_b, 16'h0000);
    rst_n = 1'b1;
    idle_bits(1'b0, 12);
    cmp("midrst_done", n_done_b - d0, 0);
    cmp("midrst_err", n_err_b - e0, 0);
    cmp("midrst_dout_after", dout_b, 16'h0000);
    send_word(1'b0, 8'hC3, 8'hC3, 1'b1, 0, 1, s1);
    cmp("post_rst_done", n_done_b - d0, 1);
    cmp("post_rst_dout", dout_b, 16'hC3C3);

    cmp("done_err_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_recv_word.md
Name: uart_recv_word

Overview:
- UART 8N1 receiver that assembles two consecutive bytes, low byte first then high byte, into one 16-bit word.
- Counterpart to the team's 16-bit word UART transmitter. Sits on the host-to-LDPC-core path and delivers received words to the encoder/decoder load logic.
- Output is a data bus plus a one-cycle valid pulse; an error pulse flags bad frames.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- UART_BPS, 115200, line baud rate.
- TIMEOUT_BITS, 16, inter-byte timeout in bit periods. Used only when UART_RX_TIMEOUT_EN is defined.
- Derived localparam BPS_CNT = CLK_FREQ/UART_BPS, integer division; 868 at defaults.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- uart_rx  input  1  asynchronous serial line; idle high.
- uart_dout  output  16  last received word, {high byte, low byte}.
- uart_done  output  1  one-cycle pulse; uart_dout is valid and newly updated.
- rx_err  output  1  one-cycle pulse on frame error or inter-byte timeout.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All state is cleared on reset:
  - uart_dout=16'h0000, uart_done=0, rx_err=0.
  - Synchronizer flops=1, FSM=IDLE, byte_idx=0, all counters=0.
- Reset asserted mid-frame aborts the frame with no done or err pulse.
- Input conditioning:
  - uart_rx passes through a 2-flop synchronizer, then one delay flop.
  - fall = delayed & ~synced, a single-cycle high-to-low detect.
  - All sampling uses the synced value.
- FSM states: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - On fall: clk_cnt=0, byte_idx=0, go to START.
  - A held-low line with no edge is ignored.
- START:
  - Sample the line when clk_cnt==BPS_CNT/2-1 (mid start bit).
  - Line low: clk_cnt=0, bit_idx=0, go to DATA.
  - Line high (glitch): return to IDLE if byte_idx==0, else to GAP. No err pulse.
- DATA:
  - Sample when clk_cnt==BPS_CNT-1, i.e. mid-bit; clk_cnt then wraps to 0.
  - Shift LSB-first into shift_reg[7:0].
  - After bit_idx==7 is sampled, go to STOP.
- STOP: sample when clk_cnt==BPS_CNT-1.
  - Stop bit 1, byte_idx==0: low_byte<=shift_reg, go to GAP.
  - Stop bit 1, byte_idx==1: on the same edge set uart_dout<={shift_reg,low_byte} and uart_done=1 for exactly one cycle; go to IDLE.
  - Stop bit 0: rx_err=1 for one cycle, discard the partial word, byte_idx=0, go to IDLE. uart_dout is unchanged.
  - A new word needs a fresh falling edge, so a stuck-low line never retriggers.
- GAP:
  - On fall: byte_idx=1, clk_cnt=0, go to START.
  - Timeout handling is under Optional Feature.
- Latency: uart_done rises about 2 + BPS_CNT/2 + 9*BPS_CNT cycles after the falling edge of the second start bit. The bench tolerance is ±3 cycles.
- uart_dout holds its value until the next uart_done. uart_done and rx_err are never asserted in the same cycle.
- Stop-bit length longer than 1 bit, and any idle gap between bytes or words, are tolerated.
- Counters: clk_cnt is 16 bits and BPS_CNT must be < 65536. bit_idx is 3 bits. The timeout counter is 32 bits and saturates only via the state exit.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - In GAP, gap_cnt increments every cycle and clears on GAP entry.
  - If gap_cnt reaches TIMEOUT_BITS*BPS_CNT-1 with no fall: rx_err pulses one cycle, low_byte is discarded, byte_idx=0, go to IDLE.
  - A fall on the same cycle as timeout wins: go to START with byte_idx=1 and no err.
- Not defined: GAP waits indefinitely for the high byte. There is no gap_cnt logic, and rx_err comes only from stop-bit errors.

Test Plan:
- Send word 0xA55A at default parameters, 868 clk per bit, bytes 0x5A then 0xA5 -> exactly one uart_done pulse, uart_dout=16'hA55A, rx_err never asserted.
- Send 0x1234 then 0xFFFF back-to-back with 1 idle bit between frames -> two done pulses, uart_dout=16'h1234 then 16'hFFFF.
- Drive a 100-cycle low glitch on uart_rx, then send 0x0001 -> no done or err for the glitch, then done with uart_dout=16'h0001.
- After receiving 0x1111, send 0xBEEF with the high byte's stop bit forced 0 -> one rx_err pulse, no done, uart_dout stays 16'h1111. Then send 0x00FF -> uart_dout=16'h00FF.
- Send byte 0x34 only, idle 20 bit-times, then bytes 0x78,0x56:
  - Macro defined: rx_err pulse about 16 bit-times after the first stop bit, then done with 16'h5678.
  - Macro undefined: done with 16'h7834.
- Pull rst_n low during data bit 4 of the low byte -> outputs 0 and no pulses. Release, then send 0xC3C3 -> done with uart_dout=16'hC3C3.
